// File: rtl/bcd_4digit_scan_driver.sv
// Four-digit multiplexed 7-segment driver: snapshots the digits once per frame,
// scans one digit per slot with a dead interval, and blanks leading zeros.
module bcd_4digit_scan_driver #(
    parameter int PRESCALE       = 50000,
    parameter int DEAD           = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    output logic [6:0]  Segments,
    output logic        bp,
    output logic [3:0]  digit_sel,
    output logic        frame_tick
);

    localparam int              PC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);
    localparam logic [PC_W-1:0] PC_DEAD = PC_W'(DEAD);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic            BP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [3:0]      SEL_OFF = SEL_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [PC_W-1:0] pc;
    logic [1:0]      idx;
    logic [15:0]     bcd_q;
    logic [3:0]      dp_q;

    logic            slot_end;
    logic            frame_end;
    logic            lz3, lz2, lz1;
    logic            blank_cur;
    logic [3:0]      nibble;
    logic [6:0]      seg_next;
    logic            bp_next;
    logic [3:0]      sel_next;

    // Active-high gfedcba glyphs; b and d are lower-case so they differ from 8 and 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign slot_end  = (pc == PC_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    // Blanking chain runs from the leftmost digit down; digit 0 always shows.
    assign lz3 = BLANK_LEADING && (bcd_q[15:12] == 4'h0);
    assign lz2 = lz3 && (bcd_q[11:8] == 4'h0);
    assign lz1 = lz2 && (bcd_q[7:4] == 4'h0);

    always_comb begin
        nibble    = bcd_q[3:0];
        blank_cur = 1'b0;
        case (idx)
            2'd0: begin
                nibble    = bcd_q[3:0];
                blank_cur = 1'b0;
            end
            2'd1: begin
                nibble    = bcd_q[7:4];
                blank_cur = lz1;
            end
            2'd2: begin
                nibble    = bcd_q[11:8];
                blank_cur = lz2;
            end
            default: begin
                nibble    = bcd_q[15:12];
                blank_cur = lz3;
            end
        endcase
    end

    always_comb begin
        seg_next = blank_cur ? 7'h00 : hex_to_seg(nibble);
        bp_next  = dp_q[idx];
        sel_next = (pc >= PC_DEAD) ? (4'b0001 << idx) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            idx        <= 2'd0;
            bcd_q      <= 16'h0000;
            dp_q       <= 4'h0;
            frame_tick <= 1'b0;
            Segments   <= SEG_OFF;
            bp         <= BP_OFF;
            digit_sel  <= SEL_OFF;
        end else begin
            pc <= slot_end ? '0 : pc + PC_ONE;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            if (frame_end) begin
                bcd_q <= bcd_in;
                dp_q  <= dp_in;
            end
            frame_tick <= frame_end;
            // Polarity is applied only here so all upstream logic stays active-high.
            Segments   <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
            bp         <= SEG_ACTIVE_LOW ? ~bp_next : bp_next;
            digit_sel  <= SEL_ACTIVE_LOW ? ~sel_next : sel_next;
        end
    end

endmodule

// File: tb/tb_bcd_4digit_scan_driver.sv
// Scoreboard bench for bcd_4digit_scan_driver: expected slot outputs are queued
// per frame from the applied digits and checked as each digit select turns on.
module tb_bcd_4digit_scan_driver;

    localparam int P  = 64;
    localparam int D  = 4;
    localparam int NV = 6;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  Segments;
    logic        bp;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    bcd_4digit_scan_driver #(
        .PRESCALE       (P),
        .DEAD           (D),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1),
        .BLANK_LEADING  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .Segments   (Segments),
        .bp         (bp),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] sb_q[$];

    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] vec_bcd [NV] = '{16'h1234, 16'h0005, 16'h0000, 16'h0A0F, 16'hF0E1, 16'h0100};
    logic [3:0]  vec_dp  [NV] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0101, 4'b0011};

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {digit_sel, bp, Segments} for slot k, all active-low.
    function automatic logic [11:0] exp_slot(input logic [15:0] bcd, input logic [3:0] dp, input int k);
        int         top;
        logic [3:0] nib;
        logic [6:0] glyph;
        logic [3:0] sel;
        top = 0;
        for (int j = 0; j < 4; j++) begin
            if (bcd[j*4 +: 4] != 4'h0) top = j;
        end
        nib   = bcd[k*4 +: 4];
        glyph = (k > top) ? 7'h00 : hex_tab[nib];
        sel   = 4'hF;
        sel[k] = 1'b0;
        return {sel, ~dp[k], ~glyph};
    endfunction

    task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp);
        for (int k = 0; k < 4; k++) sb_q.push_back(exp_slot(bcd, dp, k));
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 5*P; n++) begin
            @(negedge clk);
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val("tick_timeout", 16'd1, 16'd0);
    endtask

    task automatic set_inputs(input logic [15:0] bcd, input logic [3:0] dp);
        bcd_in = bcd;
        dp_in  = dp;
    endtask

    // Monitor: slot contents, hold during a slot, dead/active lengths, select exclusivity, tick shape.
    bit          prev_active;
    bit          run_valid;
    int          run_len;
    bit          cur_valid;
    logic [11:0] cur_exp;
    bit          tick_seen;
    bit          prev_tick;
    int          cyc;
    int          last_tick;

    always @(negedge clk) begin
        bit          act;
        logic [11:0] obs;
        if (!rst_n) begin
            prev_active = 1'b0;
            run_valid   = 1'b0;
            run_len     = 0;
            cur_valid   = 1'b0;
            tick_seen   = 1'b0;
            prev_tick   = 1'b0;
        end else begin
            cyc++;
            act = (digit_sel != 4'hF);
            obs = {digit_sel, bp, Segments};
            check_val("sel_multi", 16'($countones(~digit_sel) > 1), 16'd0);
            if (act != prev_active) begin
                if (run_valid) begin
                    if (prev_active) check_val("active_len", 16'(run_len), 16'(P - D));
                    else             check_val("dead_len", 16'(run_len), 16'(D));
                end
                run_valid = 1'b1;
                run_len   = 1;
                if (act) begin
                    if (sb_q.size() > 0) begin
                        cur_exp   = sb_q.pop_front();
                        cur_valid = 1'b1;
                        check_val("slot_out", 16'(obs), 16'(cur_exp));
                    end
                end else begin
                    cur_valid = 1'b0;
                    if (sb_q.size() > 0) check_val("dead_pattern", 16'({bp, Segments}), 16'(sb_q[0][7:0]));
                end
            end else begin
                run_len++;
                if (act && cur_valid) check_val("slot_hold", 16'(obs), 16'(cur_exp));
            end
            prev_active = act;
            if (frame_tick) begin
                check_val("tick_width", 16'(prev_tick), 16'd0);
                if (tick_seen) check_val("tick_period", 16'(cyc - last_tick), 16'(4*P));
                tick_seen = 1'b1;
                last_tick = cyc;
            end
            prev_tick = frame_tick;
        end
    end

    initial begin
        int         first_n;
        bit         found;
        logic [3:0] last_sel;

        rst_n = 1'b0;
        set_inputs(16'h0000, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_seg", 16'(Segments), 16'h007F);
        check_val("rst_bp", 16'(bp), 16'd1);
        check_val("rst_sel", 16'(digit_sel), 16'h000F);
        check_val("rst_tick", 16'(frame_tick), 16'd0);

        @(negedge clk);
        #2 rst_n = 1'b1;
        push_frame(16'h0000, 4'h0);
        set_inputs(vec_bcd[0], vec_dp[0]);

        for (int i = 0; i < NV; i++) begin
            wait_tick();
            push_frame(vec_bcd[i], vec_dp[i]);
            if (i + 1 < NV) begin
                if (i + 1 == NV - 1) begin
                    // Land the change right before the capturing edge.
                    repeat (4*P - 1) @(posedge clk);
                end else begin
                    repeat (P + 10) @(posedge clk);
                end
                #1 set_inputs(vec_bcd[i+1], vec_dp[i+1]);
            end
        end

        // Async reset inside slot 2 dead time, between clock edges.
        found    = 1'b0;
        last_sel = digit_sel;
        for (int n = 0; n < 6*P; n++) begin
            @(negedge clk);
            if (digit_sel == 4'hF && last_sel == 4'hD) begin
                found = 1'b1;
                break;
            end
            last_sel = digit_sel;
        end
        check_val("slot2_found", 16'(found), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_seg", 16'(Segments), 16'h007F);
        check_val("arst_bp", 16'(bp), 16'd1);
        check_val("arst_sel", 16'(digit_sel), 16'h000F);
        check_val("arst_tick", 16'(frame_tick), 16'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        push_frame(16'h0000, 4'h0);

        first_n = 0;
        for (int n = 1; n <= 2*P; n++) begin
            @(posedge clk);
            #1;
            if (digit_sel != 4'hF) begin
                first_n = n;
                break;
            end
        end
        check_val("first_active_cycle", 16'(first_n), 16'(D + 1));
        check_val("first_active_sel", 16'(digit_sel), 16'h000E);

        for (int f = 0; f < 4; f++) begin
            wait_tick();
            push_frame(vec_bcd[NV-1], vec_dp[NV-1]);
        end

        for (int n = 0; n < 8*P; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        repeat (P) @(negedge clk);
        check_val("queue_left", 16'(sb_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_4digit_scan_driver.md
Name: bcd_4digit_scan_driver

Overview:
Time-multiplexed driver for a 4-digit common-anode 7-segment display, one digit position further along than the single-digit BCD decoder. It takes four BCD/hex nibbles plus decimal points from upstream (counters), snapshots them once per frame, scans the digits at a fixed rate with anti-ghosting dead time, and blanks leading zeros. It sits between the application counters and the board pins.

Parameters:
PRESCALE, 50000, clk cycles per digit slot (1 kHz slot rate at 50 MHz; legal range 32..2^20).
DEAD, 16, cycles at the start of each slot with all digit selects inactive (legal range 1..PRESCALE-1).
SEG_ACTIVE_LOW, 1, 1 means Segments and bp drive 0 to light.
SEL_ACTIVE_LOW, 1, 1 means digit_sel drives 0 to enable a digit.
BLANK_LEADING, 1, 1 enables leading-zero blanking.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
bcd_in  input  16  digit3..digit0 nibbles; [3:0] is the rightmost digit
dp_in  input  4  decimal point per digit; bit i belongs to digit i
Segments  output  7  segment drive, bit0=a .. bit6=g
bp  output  1  decimal point drive
digit_sel  output  4  digit enables; bit i selects digit i
frame_tick  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Clock/reset: one clock (clk). rst_n is asynchronous, active-low. Internal state is released synchronously on the first clk edge after deassertion.
- Reset values:
  - prescale counter pc=0, slot index idx=0, snapshot registers (bcd_q, dp_q)=0.
  - frame_tick=0.
  - digit_sel all inactive (4'hF when active-low).
  - Segments all off (7'h7F when active-low); bp off.
- Prescaler: pc counts 0..PRESCALE-1, then wraps to 0.
- Slot index: idx advances 0→1→2→3→0 in the cycle where pc==PRESCALE-1.
- Snapshot: in the cycle where pc==PRESCALE-1 and idx==3, bcd_q<=bcd_in and dp_q<=dp_in, and frame_tick goes high on the next cycle for exactly one cycle.
  - Input changes at any other time have no visible effect until the next snapshot.
  - The first frame after reset displays the reset snapshot (all zero).
- Decode: each nibble maps to hex glyphs 0-9 and A-F (standard a-g patterns; b and d lower-case). Example codes, active-high gfedcba: 0=3F, 1=06, 8=7F, A=77, F=71.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit 3 is blank if it is 0.
  - Digit 2 is blank if digits 3 and 2 are 0.
  - Digit 1 is blank if digits 3..1 are 0.
  - Digit 0 is never blanked.
  - A blanked digit drives all segments off, but its dp still follows dp_q.
  - Blanking is computed from the snapshot only.
- Dead time: while pc<DEAD, digit_sel is all inactive. Segments/bp already carry the new slot's pattern.
- Output timing: Segments, bp and digit_sel are registered, one clk after the (pc, idx) state they are derived from.
- Exactly one digit_sel bit is active outside dead time; none is active inside it.
- Polarity: parameters invert at the output registers only; internal logic is active-high.
- Reset mid-scan: all outputs go to their reset values immediately (asynchronous), and the scan restarts at idx=0, pc=0.
- Boundary: input changing in the snapshot cycle itself is captured with the value present at that clk edge (no intermediate state).

Test Plan:
1. Hold bcd_in=16'h1234, dp_in=0, PRESCALE=64, DEAD=4 from reset → after the first frame_tick, slots 0..3 show 4,3,2,1 (active-low Segments 0x19,0x30,0x24,0x79). digit_sel is 4'hF for 4 cycles, then 4'hE/D/B/7 respectively for 60 cycles each.
2. bcd_in=16'h0005, BLANK_LEADING=1 → digits 3..1 Segments=0x7F, digit 0 shows 0x12. Then bcd_in=16'h0000 → digit 0 shows 0x40 and the rest are blank.
3. bcd_in=16'h0A0F, dp_in=4'b1000 → digit 3 blank with bp=0 (lit), digit 2 shows A (0x08), digit 1 shows 0 (0x40, not blanked because a higher digit is nonzero), digit 0 shows F (0x0E).
4. Change bcd_in mid-frame (slot 1) → displayed digits are unchanged until the next frame_tick. The first slot-0 after the tick shows the new value. frame_tick is exactly 1 cycle wide, every 4×PRESCALE cycles.
5. Assert rst_n low during slot 2 dead time, asynchronously between edges → Segments=0x7F, bp=1, digit_sel=4'hF, frame_tick=0 with no clk edge. After release, the first active select is 4'hE at cycle DEAD+1.
6. Run 3 full frames → check on every cycle that at most one digit_sel bit is active, and none is active during the first DEAD cycles of each slot.
